// File: rtl/bf_pkg.sv
// Shared definitions for the bf_core_v2 Brainfuck execution core:
// opcode bytes, FSM state encoding and error status codes.
package bf_pkg;

  localparam logic [7:0] OP_INC_PTR = 8'h3E; // '>'
  localparam logic [7:0] OP_DEC_PTR = 8'h3C; // '<'
  localparam logic [7:0] OP_INC     = 8'h2B; // '+'
  localparam logic [7:0] OP_DEC     = 8'h2D; // '-'
  localparam logic [7:0] OP_OUT     = 8'h2E; // '.'
  localparam logic [7:0] OP_IN      = 8'h2C; // ','
  localparam logic [7:0] OP_LOOP    = 8'h5B; // '['
  localparam logic [7:0] OP_END     = 8'h5D; // ']'
  localparam logic [7:0] OP_HALT    = 8'h00;

  typedef enum logic [3:0] {
    FETCH, EXEC, WB, OUT_WAIT, IN_WAIT, SKIP_F, SKIP_S, HALT, ERROR
  } state_e;

  localparam logic [2:0] ERR_NONE           = 3'd0;
  localparam logic [2:0] ERR_STACK_OVERFLOW = 3'd1;
  localparam logic [2:0] ERR_UNMATCHED_END  = 3'd2;
  localparam logic [2:0] ERR_UNMATCHED_LOOP = 3'd3;
  localparam logic [2:0] ERR_DATA_BOUNDS    = 3'd4;

endpackage

// File: rtl/bf_loop_stack.sv
// Loop-return address stack for bf_core_v2.
// Ports: clk, reset (sync, active-high, empties the stack), push/pop strobes,
// push_val (return pc), top (most recent entry), full, empty.
// A push while full or a pop while empty is ignored.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int STACK_DEPTH     = 8,
  parameter int PROG_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PROG_ADDR_WIDTH-1:0] push_val,
  output logic [PROG_ADDR_WIDTH-1:0] top,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [PROG_ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PTR_W:0]             cnt_q;
  logic [PTR_W-1:0]           top_idx;

  // At cnt=STACK_DEPTH the low bits are 0, so the decrement lands on the last slot.
  assign top_idx = cnt_q[PTR_W-1:0] - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign full    = (cnt_q == (PTR_W+1)'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[cnt_q[PTR_W-1:0]] <= push_val;
    end
  end

endmodule

// File: rtl/bf_core_v2.sv
// bf_core_v2: Brainfuck execution core with valid/ready stdio, forward skip
// for '[' on a zero cell, loop-stack overflow/underflow detection and
// halt/error status.
// Ports: clk, reset (sync, active-high), en (freeze when low);
//   prog_addr/prog_ren/prog_rval  - program ROM, 1-cycle read latency
//   data_addr/data_ren/data_wen/data_wval/data_rval - data RAM, 1-cycle read
//   out_data/out_valid/out_ready  - stdout channel
//   in_data/in_valid/in_ready     - stdin channel
//   halted (0x00 executed), error (0 none,1 overflow,2 ']' unmatched,
//   3 '[' unmatched, 4 data bounds).
// Build option: define BF_DATA_BOUNDS_EN to trap pointer moves past either
// end of data memory (error 4) instead of wrapping.
module bf_core_v2
  import bf_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int PROG_ADDR_WIDTH = 8,
  parameter int STACK_DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic                       prog_ren,
  input  logic [7:0]                 prog_rval,
  output logic [DATA_ADDR_WIDTH-1:0] data_addr,
  output logic                       data_ren,
  output logic                       data_wen,
  output logic [DATA_WIDTH-1:0]      data_wval,
  input  logic [DATA_WIDTH-1:0]      data_rval,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       halted,
  output logic [2:0]                 error
);

`ifdef BF_DATA_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e                     state_q;
  logic [PROG_ADDR_WIDTH-1:0] pc_q;
  logic [DATA_ADDR_WIDTH-1:0] dp_q;
  logic [PROG_ADDR_WIDTH:0]   depth_q;
  logic                       prog_ren_q, data_ren_q, data_wen_q;
  logic [DATA_WIDTH-1:0]      data_wval_q;
  logic [7:0]                 out_data_q;
  logic                       out_valid_q, in_ready_q, halted_q;
  logic [2:0]                 error_q;

  logic [PROG_ADDR_WIDTH-1:0] pc_inc_d, stk_top;
  logic [DATA_ADDR_WIDTH-1:0] dp_inc_d, dp_dec_d;
  logic                       cell_zero, exec_now, stk_push, stk_pop, stk_full, stk_empty;

  assign pc_inc_d  = pc_q + PROG_ADDR_WIDTH'(1);
  assign dp_inc_d  = dp_q + DATA_ADDR_WIDTH'(1);
  assign dp_dec_d  = dp_q - DATA_ADDR_WIDTH'(1);
  assign cell_zero = (data_rval == '0);
  assign exec_now  = en && (state_q == EXEC);
  assign stk_push  = exec_now && (prog_rval == OP_LOOP) && !cell_zero && !stk_full;
  assign stk_pop   = exec_now && (prog_rval == OP_END) && cell_zero && !stk_empty;

  bf_loop_stack #(
    .STACK_DEPTH    (STACK_DEPTH),
    .PROG_ADDR_WIDTH(PROG_ADDR_WIDTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (stk_push),
    .pop     (stk_pop),
    .push_val(pc_inc_d),
    .top     (stk_top),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  // Every transition into FETCH (or SKIP_F) arms the read strobes in the same
  // edge, so the strobes are already high during that state. Only the FETCH
  // entered from reset has to arm them itself, costing one extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      dp_q        <= '0;
      depth_q     <= '0;
      prog_ren_q  <= 1'b0;
      data_ren_q  <= 1'b0;
      data_wen_q  <= 1'b0;
      data_wval_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      halted_q    <= 1'b0;
      error_q     <= ERR_NONE;
    end else if (en) begin
      case (state_q)
        FETCH: begin
          if (prog_ren_q) begin
            prog_ren_q <= 1'b0;
            data_ren_q <= 1'b0;
            state_q    <= EXEC;
          end else begin
            prog_ren_q <= 1'b1;
            data_ren_q <= 1'b1;
          end
        end
        EXEC: begin
          case (prog_rval)
            OP_INC_PTR, OP_DEC_PTR: begin
              if (BOUNDS_EN && (prog_rval == OP_INC_PTR ? (dp_q == '1) : (dp_q == '0))) begin
                error_q <= ERR_DATA_BOUNDS;
                state_q <= ERROR;
              end else begin
                dp_q       <= (prog_rval == OP_INC_PTR) ? dp_inc_d : dp_dec_d;
                pc_q       <= pc_inc_d;
                prog_ren_q <= 1'b1;
                data_ren_q <= 1'b1;
                state_q    <= FETCH;
              end
            end
            OP_INC, OP_DEC: begin
              data_wval_q <= (prog_rval == OP_INC) ? data_rval + DATA_WIDTH'(1)
                                                   : data_rval - DATA_WIDTH'(1);
              data_wen_q  <= 1'b1;
              pc_q        <= pc_inc_d;
              state_q     <= WB;
            end
            OP_OUT: begin
              out_data_q  <= data_rval[7:0];
              out_valid_q <= 1'b1;
              state_q     <= OUT_WAIT;
            end
            OP_IN: begin
              in_ready_q <= 1'b1;
              state_q    <= IN_WAIT;
            end
            OP_LOOP: begin
              if (!cell_zero && stk_full) begin
                error_q <= ERR_STACK_OVERFLOW;
                state_q <= ERROR;
              end else if (!cell_zero) begin
                pc_q       <= pc_inc_d;
                prog_ren_q <= 1'b1;
                data_ren_q <= 1'b1;
                state_q    <= FETCH;
              end else begin
                depth_q    <= (PROG_ADDR_WIDTH+1)'(1);
                pc_q       <= pc_inc_d;
                prog_ren_q <= 1'b1;
                state_q    <= SKIP_F;
              end
            end
            OP_END: begin
              if (stk_empty) begin
                error_q <= ERR_UNMATCHED_END;
                state_q <= ERROR;
              end else begin
                // Nonzero cell jumps back to the first body instruction, keeping the entry.
                pc_q       <= cell_zero ? pc_inc_d : stk_top;
                prog_ren_q <= 1'b1;
                data_ren_q <= 1'b1;
                state_q    <= FETCH;
              end
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end
            default: begin
              pc_q       <= pc_inc_d;
              prog_ren_q <= 1'b1;
              data_ren_q <= 1'b1;
              state_q    <= FETCH;
            end
          endcase
        end
        WB: begin
          data_wen_q <= 1'b0;
          prog_ren_q <= 1'b1;
          data_ren_q <= 1'b1;
          state_q    <= FETCH;
        end
        OUT_WAIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_inc_d;
            prog_ren_q  <= 1'b1;
            data_ren_q  <= 1'b1;
            state_q     <= FETCH;
          end
        end
        IN_WAIT: begin
          if (in_valid) begin
            in_ready_q  <= 1'b0;
            data_wval_q <= DATA_WIDTH'(in_data);
            data_wen_q  <= 1'b1;
            pc_q        <= pc_inc_d;
            state_q     <= WB;
          end
        end
        SKIP_F: begin
          prog_ren_q <= 1'b0;
          state_q    <= SKIP_S;
        end
        SKIP_S: begin
          if (prog_rval == OP_HALT) begin
            error_q <= ERR_UNMATCHED_LOOP;
            state_q <= ERROR;
          end else if (prog_rval == OP_END && depth_q == (PROG_ADDR_WIDTH+1)'(1)) begin
            pc_q       <= pc_inc_d;
            prog_ren_q <= 1'b1;
            data_ren_q <= 1'b1;
            state_q    <= FETCH;
          end else begin
            if (prog_rval == OP_LOOP) depth_q <= depth_q + (PROG_ADDR_WIDTH+1)'(1);
            if (prog_rval == OP_END)  depth_q <= depth_q - (PROG_ADDR_WIDTH+1)'(1);
            pc_q       <= pc_inc_d;
            prog_ren_q <= 1'b1;
            state_q    <= SKIP_F;
          end
        end
        HALT, ERROR: ;
        default: state_q <= ERROR;
      endcase
    end
  end

  assign prog_addr = pc_q;
  assign prog_ren  = prog_ren_q;
  assign data_addr = dp_q;
  assign data_ren  = data_ren_q;
  assign data_wen  = data_wen_q;
  assign data_wval = data_wval_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign halted    = halted_q;
  assign error     = error_q;

endmodule

// File: tb/tb_bf_core_v2.sv
// Directed bench for bf_core_v2 with behavioural program ROM / data RAM.
module tb_bf_core_v2;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [7:0] prog_addr, prog_rval, data_addr, data_wval, data_rval;
  logic       prog_ren, data_ren, data_wen;
  logic [7:0] out_data, in_data;
  logic       out_valid, out_ready, in_valid, in_ready, halted;
  logic [2:0] error;

  logic [7:0] prog [256];
  logic [7:0] dmem [256];
  logic [7:0] outq [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf_core_v2 dut (
    .clk(clk), .reset(reset), .en(en),
    .prog_addr(prog_addr), .prog_ren(prog_ren), .prog_rval(prog_rval),
    .data_addr(data_addr), .data_ren(data_ren), .data_wen(data_wen),
    .data_wval(data_wval), .data_rval(data_rval),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .halted(halted), .error(error)
  );

  // Synchronous-read memories; data RAM is cleared while reset is held.
  always @(posedge clk) begin
    if (prog_ren) prog_rval <= prog[prog_addr];
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
      data_rval <= 8'h00;
    end else begin
      if (data_ren) data_rval <= dmem[data_addr];
      if (data_wen) dmem[data_addr] <= data_wval;
    end
  end

  // stdout sink: records every completed transfer.
  always @(posedge clk) begin
    if (!reset && en && out_valid && out_ready) outq.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] out0();
    return (outq.size() > 0) ? outq[0] : 8'hxx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) prog[i] = s[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    outq.delete();
    chk("reset_outputs", {8'h00, prog_ren, data_ren, data_wen, out_valid, in_ready,
                          halted, error, prog_addr, data_addr}, 32'h0);
    reset = 1'b0;
  endtask

  task automatic run_to_end(input int budget);
    for (int i = 0; i < budget && !(halted || error != 3'd0); i++) step();
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_data = 8'h00;

    // "+++." : one output of 3, clean halt
    load("+++.");
    do_reset();
    run_to_end(500);
    chk("t1_out_count", outq.size(), 1);
    chk("t1_out_data", out0(), 8'h03);
    chk("t1_halted", halted, 1'b1);
    chk("t1_error", error, 3'd0);

    // ",+." : late stdin, stalled stdout, en freeze
    out_ready = 1'b0;
    load(",+.");
    do_reset();
    for (int i = 0; i < 50 && !in_ready; i++) step();
    chk("t2_in_ready_up", in_ready, 1'b1);
    repeat (5) step();
    chk("t2_in_ready_held", in_ready, 1'b1);
    in_data = 8'h41; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    chk("t2_in_ready_drop", in_ready, 1'b0);
    for (int i = 0; i < 50 && !out_valid; i++) step();
    chk("t2_out_valid_up", out_valid, 1'b1);
    chk("t2_out_data", out_data, 8'h42);
    repeat (4) step();
    chk("t2_out_valid_held", out_valid, 1'b1);
    chk("t2_out_data_stable", out_data, 8'h42);
    en = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("t2_en_no_transfer", outq.size(), 0);
    chk("t2_en_valid_held", out_valid, 1'b1);
    en = 1'b1;
    run_to_end(500);
    chk("t2_out_count", outq.size(), 1);
    chk("t2_out_value", out0(), 8'h42);
    chk("t2_halted", halted, 1'b1);

    // "[+.]." on zero cell: body skipped, single 0x00
    load("[+.].");
    do_reset();
    run_to_end(500);
    chk("t3_out_count", outq.size(), 1);
    chk("t3_out_data", out0(), 8'h00);
    chk("t3_halted", halted, 1'b1);

    // nested skip "[[.]]+." resumes after the outer ']'
    load("[[.]]+.");
    do_reset();
    run_to_end(500);
    chk("t3n_out_count", outq.size(), 1);
    chk("t3n_out_data", out0(), 8'h01);
    chk("t3n_error", error, 3'd0);

    // "++[->+<]>." : move loop, output 2
    load("++[->+<]>.");
    do_reset();
    run_to_end(1000);
    chk("t4_out_data", out0(), 8'h02);
    chk("t4_out_count", outq.size(), 1);
    chk("t4_cell0", dmem[0], 8'h00);
    chk("t4_cell1", dmem[1], 8'h02);
    chk("t4_halted", halted, 1'b1);
    chk("t4_stack_empty", dut.u_stack.empty, 1'b1);

    // nine nested '[' on nonzero cell -> overflow
    load("+[[[[[[[[[");
    do_reset();
    run_to_end(500);
    chk("t5_overflow", error, 3'd1);
    chk("t5_not_halted", halted, 1'b0);
    chk("t5_enables_off", {prog_ren, data_ren, data_wen}, 3'b000);

    // lone ']' -> unmatched end
    load("]");
    do_reset();
    run_to_end(500);
    chk("t5_unmatched_end", error, 3'd2);

    // '[' on zero cell never closed -> unmatched loop
    load("[+");
    do_reset();
    run_to_end(500);
    chk("t5_unmatched_loop", error, 3'd3);
    chk("t5_no_output", outq.size(), 0);

    // "<." : wrap or bounds trap depending on build
    load("<.");
    do_reset();
    run_to_end(500);
`ifdef BF_DATA_BOUNDS_EN
    chk("t6_bounds_error", error, 3'd4);
    chk("t6_no_output", outq.size(), 0);
    chk("t6_addr_kept", data_addr, 8'h00);
`else
    chk("t6_wrap_addr", data_addr, 8'hFF);
    chk("t6_out_count", outq.size(), 1);
    chk("t6_out_data", out0(), 8'h00);
    chk("t6_error", error, 3'd0);
`endif

    // reset while waiting on stdout: valid drops, nothing transferred
    out_ready = 1'b0;
    load("+.");
    do_reset();
    for (int i = 0; i < 50 && !out_valid; i++) step();
    chk("t7_out_valid_up", out_valid, 1'b1);
    reset = 1'b1;
    step();
    chk("t7_valid_dropped", out_valid, 1'b0);
    out_ready = 1'b1;
    step();
    chk("t7_no_transfer", outq.size(), 0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
